// File: rtl/uar_pkg.sv
// rtl/uar_pkg.sv - shared constants and one-hot state encoding for the uar_rx receiver.
// UAR_PARITY_EN widens the FSM to 5 bits to add PARITY_BIT_ST.
package uar_pkg;

  localparam int UAR_DATA_W     = 8;
  localparam int UAR_OVERSAMPLE = 16;

`ifdef UAR_PARITY_EN
  localparam int UAR_STATE_W = 5;
`else
  localparam int UAR_STATE_W = 4;
`endif

  typedef enum logic [UAR_STATE_W-1:0] {
    IDLE          = UAR_STATE_W'(1),
    START_BIT_ST  = UAR_STATE_W'(2),
    DATA_BITS_ST  = UAR_STATE_W'(4),
    STOP_BIT_ST   = UAR_STATE_W'(8)
`ifdef UAR_PARITY_EN
    , PARITY_BIT_ST = UAR_STATE_W'(16)
`endif
  } uar_state_t;

endpackage

// File: rtl/uar_sync.sv
// rtl/uar_sync.sv - 2-flop synchronizer for the asynchronous serial line, resets to idle-high.
module uar_sync (
  input  logic clk_x,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_x or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uar_rx.sv
// rtl/uar_rx.sv - UART receiver, 8N1 (8E1 with UAR_PARITY_EN), 16x-style oversampling.
// Samples at bit centres and leaves at the stop-bit centre so frames can run back-to-back.
module uar_rx
  import uar_pkg::*;
#(
  parameter int OVERSAMPLE = UAR_OVERSAMPLE
) (
  input  logic                  clk_x,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic                  rx_in,
  output logic [UAR_DATA_W-1:0] dout,
  output logic                  dout_vld,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  logic                  rx_s;
  uar_state_t            state, state_nxt;
  logic [TW-1:0]         tick_cnt, tick_cnt_nxt;
  logic [2:0]            bit_cnt, bit_cnt_nxt;
  logic [UAR_DATA_W-1:0] shreg, shreg_nxt;
  logic [UAR_DATA_W-1:0] dout_nxt;
  logic                  line_ok, line_ok_nxt;
  logic                  vld_nxt, ferr_nxt, perr_nxt, busy_nxt;
  logic                  par_bad;

  uar_sync u_sync (
    .clk_x(clk_x),
    .rst_n(rst_n),
    .d    (rx_in),
    .q    (rx_s)
  );

`ifdef UAR_PARITY_EN
  logic par_bad_nxt;

  always_ff @(posedge clk_x or negedge rst_n) begin
    if (!rst_n) par_bad <= 1'b0;
    else        par_bad <= par_bad_nxt;
  end
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk_x or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      line_ok    <= 1'b1;
      dout       <= '0;
      dout_vld   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      tick_cnt   <= tick_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      line_ok    <= line_ok_nxt;
      dout       <= dout_nxt;
      dout_vld   <= vld_nxt;
      frame_err  <= ferr_nxt;
      parity_err <= perr_nxt;
      busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    dout_nxt     = dout;
    line_ok_nxt  = line_ok;
    vld_nxt      = 1'b0;
    ferr_nxt     = 1'b0;
    perr_nxt     = 1'b0;
`ifdef UAR_PARITY_EN
    par_bad_nxt  = par_bad;
`endif

    // Any high sample re-arms start detection after a break.
    if (sample_tick && rx_s) line_ok_nxt = 1'b1;

    case (state)
      IDLE: begin
        if (sample_tick && !rx_s && line_ok) begin
          state_nxt    = START_BIT_ST;
          tick_cnt_nxt = '0;
        end
      end
      START_BIT_ST: begin
        if (sample_tick) begin
          tick_cnt_nxt = tick_cnt + 1'b1;
          if (tick_cnt == HALF_LAST) begin
            if (!rx_s) begin
              state_nxt    = DATA_BITS_ST;
              tick_cnt_nxt = '0;
              bit_cnt_nxt  = '0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      DATA_BITS_ST: begin
        if (sample_tick) begin
          tick_cnt_nxt = tick_cnt + 1'b1;
          if (tick_cnt == FULL_LAST) begin
            shreg_nxt   = {rx_s, shreg[UAR_DATA_W-1:1]};
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UAR_PARITY_EN
              state_nxt = PARITY_BIT_ST;
`else
              state_nxt = STOP_BIT_ST;
`endif
            end
          end
        end
      end
`ifdef UAR_PARITY_EN
      PARITY_BIT_ST: begin
        if (sample_tick) begin
          tick_cnt_nxt = tick_cnt + 1'b1;
          if (tick_cnt == FULL_LAST) begin
            par_bad_nxt = (^shreg) ^ rx_s;
            state_nxt   = STOP_BIT_ST;
          end
        end
      end
`endif
      STOP_BIT_ST: begin
        if (sample_tick) begin
          tick_cnt_nxt = tick_cnt + 1'b1;
          if (tick_cnt == FULL_LAST) begin
            state_nxt = IDLE;
            if (!rx_s) begin
              ferr_nxt    = 1'b1;
              line_ok_nxt = 1'b0;
            end else if (par_bad) begin
              perr_nxt = 1'b1;
            end else begin
              vld_nxt  = 1'b1;
              dout_nxt = shreg;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_uar_rx.sv
// tb/tb_uar_rx.sv - self-checking bench for uar_rx: frame-level scoreboard plus directed cases.
// Parity cases are compiled in when UAR_PARITY_EN is defined.
module tb_uar_rx;

  localparam int OS = 16;
`ifdef UAR_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clk_x = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] dout;
  logic       dout_vld, frame_err, parity_err, busy;

  int total = 0;
  int bad = 0;
  int tp = 4;
  int tick_ctr = 0;
  int tick_idx = 0;
  int n_vld = 0, n_ferr = 0, n_perr = 0, n_sent = 0;
  logic [7:0] model_dout = 8'h00;

  // kind: 0 = byte delivered, 1 = frame error, 2 = parity error
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         stop_tick;
  } ev_t;
  ev_t expq[$];

  uar_rx #(.OVERSAMPLE(OS)) dut (
    .clk_x      (clk_x),
    .rst_n      (rst_n),
    .sample_tick(sample_tick),
    .rx_in      (rx_in),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk_x = ~clk_x;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(negedge clk_x);
    if (tick_ctr >= tp - 1) begin
      sample_tick = 1'b1;
      tick_ctr    = 0;
      tick_idx++;
    end else begin
      sample_tick = 1'b0;
      tick_ctr++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin : compare
    ev_t e;
    int  act_kind;
    int  dt;
    forever begin
      @(negedge clk_x);
      if (rst_n) begin
        if (dout_vld || frame_err || parity_err) begin
          chk("single_pulse", 32'(dout_vld) + 32'(frame_err) + 32'(parity_err), 1);
          act_kind = dout_vld ? 0 : (frame_err ? 1 : 2);
          if (dout_vld) n_vld++;
          if (frame_err) n_ferr++;
          if (parity_err) n_perr++;
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got kind %0d want no event (t=%0t)", act_kind, $time);
          end else begin
            e  = expq.pop_front();
            dt = tick_idx - e.stop_tick;
            chk("event_kind", act_kind, e.kind);
            chk("event_time", (dt >= OS / 2 && dt <= OS / 2 + 4), 1);
            if (e.kind == 0) model_dout = e.data;
          end
        end
        chk("dout", dout, model_dout);
      end
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk_x); while (!sample_tick);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                            input int hold_low);
    ev_t e;
    rx_in = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      wait_ticks(OS);
    end
    if (PAR_ON) begin
      rx_in = (^d) ^ par_flip;
      wait_ticks(OS);
    end
    e.kind      = !stop ? 1 : ((PAR_ON && par_flip) ? 2 : 0);
    e.data      = d;
    e.stop_tick = tick_idx;
    expq.push_back(e);
    n_sent++;
    rx_in = stop;
    wait_ticks(OS + hold_low);
  endtask

  initial begin : main
    int         ev0, f0, v0, p0, gap;
    logic [7:0] d;
    logic       stop, pf;
    logic [7:0] d5a;

    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (5) @(posedge clk_x);
    #1;
    chk("rst_dout", dout, 8'h00);
    chk("rst_vld", dout_vld, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(3);

    // 0xA5 with a tick every 4 clocks
    tp = 4;
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    idle(4);
    chk("a5_dout", dout, 8'hA5);
    chk("a5_vld_cnt", n_vld, 1);
    chk("a5_err_cnt", n_ferr + n_perr, 0);
    chk("a5_busy_idle", busy, 0);

    // 5-tick glitch: false start, no result
    ev0   = n_vld + n_ferr + n_perr;
    rx_in = 1'b0;
    wait_ticks(5);
    chk("glitch_busy_hi", busy, 1);
    rx_in = 1'b1;
    wait_ticks(OS);
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_no_pulse", n_vld + n_ferr + n_perr, ev0);

    // low stop bit then a 30-bit break
    f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0, 30 * OS);
    chk("break_ferr_once", n_ferr - f0, 1);
    chk("break_dout_kept", dout, 8'hA5);
    idle(OS);
    send_frame(8'h81, 1'b1, 1'b0, 0);
    idle(4);
    chk("after_break_dout", dout, 8'h81);

    // back-to-back, no idle between frames
    v0 = n_vld;
    send_frame(8'h00, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 0);
    idle(4);
    chk("b2b_vld_cnt", n_vld - v0, 2);
    chk("b2b_dout", dout, 8'hFF);

    // reset in the middle of data bit 4 of 0x5A
    d5a   = 8'h5A;
    rx_in = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx_in = d5a[i];
      wait_ticks(OS);
    end
    rx_in = d5a[4];
    wait_ticks(OS / 2);
    chk("mid_frame_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    expq.delete();
    model_dout = 8'h00;
    chk("rst_mid_dout", dout, 8'h00);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_pulses", {dout_vld, frame_err, parity_err}, 0);
    rx_in = 1'b1;
    repeat (3) @(posedge clk_x);
    #1;
    rst_n = 1'b1;
    idle(2 * OS);
    send_frame(8'h12, 1'b1, 1'b0, 0);
    idle(4);
    chk("post_rst_dout", dout, 8'h12);

    if (PAR_ON) begin
      p0 = n_perr;
      send_frame(8'h07, 1'b1, 1'b0, 0);
      idle(4);
      chk("par_good_dout", dout, 8'h07);
      send_frame(8'h07, 1'b1, 1'b1, 0);
      idle(4);
      chk("par_bad_cnt", n_perr - p0, 1);
      chk("par_bad_dout", dout, 8'h07);
    end

    // randomized frames, tick rates and gaps
    for (int k = 0; k < 24; k++) begin
      tp   = $urandom_range(2, 4);
      d    = 8'($urandom);
      stop = ($urandom_range(0, 9) != 0);
      pf   = ($urandom_range(0, 3) == 0);
      send_frame(d, stop, pf, 0);
      gap = stop ? $urandom_range(0, 3) : 3 + $urandom_range(0, 3);
      idle(gap);
    end
    idle(2 * OS);

    chk("queue_drained", expq.size(), 0);
    chk("no_stray_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
